// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus a carry flip-flop, one operand bit per clock, LSB first.
// Operands are captured on an accepted start; the registered result and a one-cycle done pulse appear WIDTH cycles later.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nxt;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  logic             s_bit;
  logic             c_bit;
  logic             last;
  logic             load;
  logic             step;

  // Returns {carry_out, sum_bit}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    full_add = {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
  endfunction

  assign {c_bit, s_bit} = full_add(a_sh[0], b_sh[0], carry);

  // New sum bit enters at the MSB; the shift form also holds for WIDTH == 1.
  assign acc_nxt = WIDTH'({s_bit, acc} >> 1);

  assign last = (cnt == LAST);
  assign load = (state == IDLE) && start;
  assign step = (state == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Serial datapath: load on accept, one bit per RUN cycle, publish on the last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (load) begin
      a_sh  <= a;
      b_sh  <= b;
      acc   <= '0;
      carry <= cin;
      cnt   <= '0;
    end else if (step) begin
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      acc   <= acc_nxt;
      carry <= c_bit;
      cnt   <= cnt + 1'b1;
      if (last) begin
        sum  <= acc_nxt;
        cout <= c_bit;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: WIDTH=8 and WIDTH=1 instances, directed tables, corner sequences and a random run.
// Expected results go into per-instance queues when start is driven and are popped on each done pulse.
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       start1, cin1, busy1, done1, cout1;
  logic [0:0] a1, b1, sum1;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       co;
  } vec_t;

  typedef struct {
    logic [7:0] s;
    logic       co;
    int         due;
  } exp_t;

  exp_t q8[$];
  exp_t q1[$];
  exp_t e8, e1;
  vec_t tbl8[4];
  vec_t tbl1[8];
  logic [1:0] fa_exp[8];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  // Scoreboard for the 8-bit instance.
  logic [7:0] prev_s8;
  logic       prev_c8;
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy8 && done8) begin
        failures++;
        $display("FAIL busy_done_overlap8 actual busy=1 done=1 required not both");
      end
      if (!done8 && (sum8 !== prev_s8 || cout8 !== prev_c8)) begin
        failures++;
        $display("FAIL result_unstable8 actual=0x%0h/%0b required=0x%0h/%0b", sum8, cout8, prev_s8, prev_c8);
      end
      if (done8) begin
        if (q8.size() == 0) begin
          failures++;
          $display("FAIL unexpected_done8 actual done=1 required done=0 at cycle %0d", cyc);
        end else begin
          e8 = q8.pop_front();
          chk("sum8", sum8, e8.s);
          chk("cout8", cout8, e8.co);
          chk("latency8", cyc, e8.due);
        end
      end else if (q8.size() > 0 && cyc > q8[0].due) begin
        failures++;
        $display("FAIL timeout8 actual no done by cycle %0d required done at cycle %0d", cyc, q8[0].due);
        void'(q8.pop_front());
      end
    end
    prev_s8 = sum8;
    prev_c8 = cout8;
  end

  // Scoreboard for the 1-bit instance.
  logic prev_s1;
  logic prev_c1;
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy1 && done1) begin
        failures++;
        $display("FAIL busy_done_overlap1 actual busy=1 done=1 required not both");
      end
      if (!done1 && (sum1[0] !== prev_s1 || cout1 !== prev_c1)) begin
        failures++;
        $display("FAIL result_unstable1 actual=%0b/%0b required=%0b/%0b", sum1[0], cout1, prev_s1, prev_c1);
      end
      if (done1) begin
        if (q1.size() == 0) begin
          failures++;
          $display("FAIL unexpected_done1 actual done=1 required done=0 at cycle %0d", cyc);
        end else begin
          e1 = q1.pop_front();
          chk("sum1", {7'd0, sum1}, e1.s);
          chk("cout1", cout1, e1.co);
          chk("latency1", cyc, e1.due);
        end
      end else if (q1.size() > 0 && cyc > q1[0].due) begin
        failures++;
        $display("FAIL timeout1 actual no done by cycle %0d required done at cycle %0d", cyc, q1[0].due);
        void'(q1.pop_front());
      end
    end
    prev_s1 = sum1[0];
    prev_c1 = cout1;
  end

  // One 8-bit addition; inputs are scrambled right after the start edge.
  task automatic add8(input logic [7:0] x, input logic [7:0] y, input logic c,
                      input logic [7:0] es, input logic eco);
    int nb = 0;
    a8 = x; b8 = y; cin8 = c; start8 = 1'b1;
    q8.push_back('{es, eco, cyc + 9});
    @(posedge clk); #1;
    start8 = 1'b0; a8 = ~x; b8 = ~y; cin8 = ~c;
    if (busy8) nb++;
    repeat (8) begin
      @(posedge clk); #1;
      if (busy8) nb++;
    end
    chk("busy_cycles8", nb, 8);
    @(posedge clk); #1;
  endtask

  task automatic add1(input logic x, input logic y, input logic c,
                      input logic es, input logic eco);
    a1 = x; b1 = y; cin1 = c; start1 = 1'b1;
    q1.push_back('{{7'd0, es}, eco, cyc + 2});
    @(posedge clk); #1;
    start1 = 1'b0;
    chk("busy1_run", busy1, 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] x, y;
    logic       c;
    logic [8:0] t;
    logic [2:0] idx;

    tbl8[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    tbl8[1] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
    tbl8[2] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
    tbl8[3] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    fa_exp  = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b11};
    for (int i = 0; i < 8; i++) begin
      idx = i[2:0];
      tbl1[i] = '{{7'd0, idx[2]}, {7'd0, idx[1]}, idx[0], {7'd0, fa_exp[i][1]}, fa_exp[i][0]};
    end

    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy8", busy8, 0);
    chk("rst_done8", done8, 0);
    chk("rst_sum8", sum8, 0);
    chk("rst_cout8", cout8, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("idle_busy8", busy8, 0);
      chk("idle_done8", done8, 0);
      chk("idle_sum8", sum8, 0);
      chk("idle_cout8", cout8, 0);
      chk("idle_busy1", busy1, 0);
    end

    for (int i = 0; i < 4; i++)
      add8(tbl8[i].a, tbl8[i].b, tbl8[i].cin, tbl8[i].s, tbl8[i].co);

    // Start re-pulsed while busy with new operands held until IDLE.
    a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    q8.push_back('{8'h10, 1'b0, cyc + 9});
    @(posedge clk); #1;
    start8 = 1'b0; a8 = 8'hFF; b8 = 8'hFF;
    repeat (2) @(posedge clk);
    #1;
    start8 = 1'b1;
    @(posedge clk); #1;
    chk("busy_on_restart", busy8, 1);
    repeat (6) @(posedge clk);
    #1;
    q8.push_back('{8'hFE, 1'b1, cyc + 9});
    @(posedge clk); #1;
    start8 = 1'b0;
    chk("busy_after_idle_accept", busy8, 1);
    repeat (9) @(posedge clk);
    #1;

    // Reset in the middle of RUN.
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("midrun_busy_before_rst", busy8, 1);
    rst_n = 1'b0;
    #1;
    chk("midrun_rst_busy8", busy8, 0);
    chk("midrun_rst_done8", done8, 0);
    chk("midrun_rst_sum8", sum8, 0);
    chk("midrun_rst_cout8", cout8, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    add8(8'h80, 8'h80, 1'b0, 8'h00, 1'b1);

    for (int i = 0; i < 8; i++)
      add1(tbl1[i].a[0], tbl1[i].b[0], tbl1[i].cin, tbl1[i].s[0], tbl1[i].co);

    // Back-to-back random additions with start held high.
    start8 = 1'b1;
    for (int i = 0; i < 500; i++) begin
      x = 8'($urandom);
      y = 8'($urandom);
      c = 1'($urandom_range(0, 1));
      a8 = x; b8 = y; cin8 = c;
      t = {1'b0, x} + {1'b0, y} + {8'd0, c};
      q8.push_back('{t[7:0], t[8], cyc + 9});
      repeat (10) @(posedge clk);
      #1;
    end
    start8 = 1'b0;

    repeat (12) @(posedge clk);
    #1;
    chk("q8_drained", q8.size(), 0);
    chk("q1_drained", q1.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
